// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch stage: special instruction words,
// default memory depth and the fetch FSM state type.
package mips_pkg;

    localparam logic [31:0] NOP_WORD           = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD          = 32'hFFFF_FFFF;
    localparam int          DEFAULT_IMEM_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } if_state_e;

endpackage : mips_pkg

// File: rtl/if_stage_if.sv
// Control, redirect, program-load and IF/ID signals of the fetch stage.
// The master side drives control and load inputs; the slave side is the stage itself.
interface if_stage_if #(
    parameter int IMEM_DEPTH = mips_pkg::DEFAULT_IMEM_DEPTH
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic          enable;
    logic          stall;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          jump;
    logic [31:0]   jump_target;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic [31:0]   pc;
    logic [31:0]   if_id_instr;
    logic [31:0]   if_id_pc_plus4;
    logic          halted;

    modport master (
        output enable, stall, branch_taken, branch_target, jump, jump_target,
               imem_wr_en, imem_wr_addr, imem_wr_data,
        input  pc, if_id_instr, if_id_pc_plus4, halted
    );

    modport slave (
        input  enable, stall, branch_taken, branch_target, jump, jump_target,
               imem_wr_en, imem_wr_addr, imem_wr_data,
        output pc, if_id_instr, if_id_pc_plus4, halted
    );

endinterface : if_stage_if

// File: rtl/if_stage_instruction_memory.sv
// Word-addressed instruction memory: synchronous load port, combinational read
// by byte address; addresses beyond the array return NOP.
module instruction_memory
    import mips_pkg::*;
#(
    parameter int DEPTH = DEFAULT_IMEM_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];
    logic        in_range;
    logic        unused_byte_offset;

    // NOTE: the array has no reset; a loaded program must survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign in_range           = (rd_addr[31:AW+2] == '0);
    assign rd_data            = in_range ? mem[rd_addr[AW+1:2]] : NOP_WORD;
    assign unused_byte_offset = ^rd_addr[1:0];

endmodule : instruction_memory

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and IDLE/RUN/HALTED FSM.
// Define IF_STAGE_HALT_DETECT_EN to stop fetching on HALT_WORD.
module if_stage
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic        clk,
    input logic        reset,
    if_stage_if.slave  bus
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] fetch_word;
    logic [31:0] pc_plus4;
    logic        mem_we;
    logic        is_halt;

    // Program loads are only legal while idle, and never during reset.
    assign mem_we   = bus.imem_wr_en && !reset && (state_q == ST_IDLE);
    assign pc_plus4 = pc_q + 32'd4;

    instruction_memory #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (bus.imem_wr_addr),
        .wr_data (bus.imem_wr_data),
        .rd_addr (pc_q),
        .rd_data (fetch_word)
    );

`ifdef IF_STAGE_HALT_DETECT_EN
    assign is_halt    = (fetch_word == HALT_WORD);
    assign bus.halted = (state_q == ST_HALTED);
`else
    assign is_halt    = 1'b0;
    assign bus.halted = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        unique case (state_q)
            ST_IDLE: begin
                instr_d = NOP_WORD;
                pc4_d   = 32'd0;
                if (bus.enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.branch_taken) begin
                    pc_d    = bus.branch_target;
                    instr_d = NOP_WORD;
                    pc4_d   = 32'd0;
                end else if (bus.jump) begin
                    pc_d    = bus.jump_target;
                    instr_d = NOP_WORD;
                    pc4_d   = 32'd0;
                end else if (bus.stall || !bus.enable) begin
                    pc_d    = pc_q;
                end else if (is_halt) begin
                    instr_d = NOP_WORD;
                    pc4_d   = 32'd0;
                    state_d = ST_HALTED;
                end else begin
                    pc_d    = pc_plus4;
                    instr_d = fetch_word;
                    pc4_d   = pc_plus4;
                end
            end
            ST_HALTED: begin
                instr_d = NOP_WORD;
                pc4_d   = 32'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc_plus4 = pc4_q;

endmodule : if_stage

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, instruction-memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 enable  in  1  run/step enable; low freezes PC and IF/ID.
REQ-006 stall  in  1  hazard stall; holds PC and IF/ID.
REQ-007 branch_taken  in  1  taken branch resolved downstream; redirect plus flush.
REQ-008 branch_target  in  32  branch destination byte address.
REQ-009 jump  in  1  jump decoded in ID; redirect plus flush.
REQ-010 jump_target  in  32  jump destination byte address.
REQ-011 imem_wr_en  in  1  program-load write strobe.
REQ-012 imem_wr_addr  in  log2(IMEM_DEPTH)  word address for the load.
REQ-013 imem_wr_data  in  32  instruction word for the load.
REQ-014 pc  out  32  current fetch address.
REQ-015 if_id_instr  out  32  registered instruction to ID; op_code is [31:26].
REQ-016 if_id_pc_plus4  out  32  registered PC+4 of that instruction.
REQ-017 halted  out  1  high while in HALTED.

Function
REQ-018 SHALL implement FSM IDLE, RUN, HALTED; reset enters IDLE.
REQ-019 IDLE: PC held, IF/ID = NOP (32'h0), pc_plus4 = 0; moves to RUN on first cycle enable=1.
REQ-020 SHALL accept imem writes only in IDLE; writes in RUN/HALTED are ignored, with memory unchanged.
REQ-021 RUN per-cycle priority: branch_taken > jump > (stall or !enable) > sequential.
REQ-022 branch_taken: PC <= branch_target; IF/ID <= NOP, regardless of stall, jump or enable.
REQ-023 jump without branch_taken: PC <= jump_target; IF/ID <= NOP, regardless of stall or enable.
REQ-024 stall or !enable without redirect: PC and IF/ID hold their values.
REQ-025 Sequential case: IF/ID <= {imem[pc], pc+4}; PC <= pc+4; fetch-to-IF/ID latency is 1 cycle.
REQ-026 Memory read SHALL be combinational on pc[log2(IMEM_DEPTH)+1:2].
REQ-027 pc >= 4*IMEM_DEPTH SHALL fetch NOP.
REQ-028 pc[1:0] SHALL be ignored for indexing.
REQ-029 PC+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC -> 0.
REQ-030 Fetch of HALT_WORD (32'hFFFF_FFFF) in a sequential cycle SHALL load NOP into IF/ID, hold PC, and enter HALTED next cycle.
REQ-031 A redirect in the same cycle as a HALT_WORD fetch SHALL win; no halt occurs.
REQ-032 HALTED: PC frozen, IF/ID = NOP, redirects ignored; only reset exits HALTED.

Reset
REQ-033 reset SHALL set pc=RESET_PC, if_id_instr=0, if_id_pc_plus4=0, halted=0, FSM=IDLE.
REQ-034 Reset mid-RUN SHALL discard in-flight IF/ID content.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 reset SHALL take priority over imem_wr_en.

Configuration
REQ-037 Macro IF_STAGE_HALT_DETECT_EN defined: REQ-030 to REQ-032 apply.
REQ-038 Macro absent: HALT_WORD is fetched as an ordinary instruction, HALTED is unreachable, and halted is tied 0.

Structure
REQ-039 Shared package mips_pkg SHALL hold NOP_WORD, HALT_WORD, default IMEM_DEPTH, and the FSM state type.
REQ-040 Memory array plus load port SHALL be sub-module INSTRUCTION_MEMORY, with a combinational read and a synchronous write.

Verification
REQ-041 Load words 0x20010005, 0x20020003 and 0xFFFFFFFF, then enable -> if_id_instr 0x20010005 then 0x20020003 with pc_plus4 4 and 8; then halted=1 and pc=8 stays.
REQ-042 In RUN at pc=0x10, stall=1 for 3 cycles -> pc and IF/ID unchanged for 3 cycles; sequential fetch from 0x10 resumes.
REQ-043 At pc=0x14 with stall=1, branch_taken=1, branch_target=0x40, jump=1, jump_target=0x80 -> next pc=0x40, if_id_instr=0.
REQ-044 Write to imem_wr_addr 3 during RUN -> word 3 unchanged on a later fetch of pc=0x0C.
REQ-045 Jump to 0x400 with IMEM_DEPTH=256 -> NOP fetched; RESET_PC=0xFFFFFFFC sequential -> pc wraps to 0.
REQ-046 Assert reset mid-RUN -> next cycle pc=RESET_PC, IF/ID=0, FSM IDLE, and loaded program still present.
